// File: rtl/shiftreg_pkg.sv
// Shared state encoding and sizing helpers for the delay-line controller.
package shiftreg_pkg;

   localparam int DEPTH_DEF = 500;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FULL,
      S_FLUSH
   } state_e;

   function automatic int cnt_width(input int d);
      int w;
      w = 1;
      while ((1 << w) <= d) w++;
      return w;
   endfunction

endpackage

// File: rtl/shiftreg_ctrl.sv
// Valid/ready controller for an external fixed-length 8-bit delay line.
// Tracks occupancy and drains with bubble shifts on flush.
module shiftreg_ctrl
   import shiftreg_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          flush,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic          sr_shift,
   output logic [7:0]    sr_data_in,
   input  logic [7:0]    sr_data_out,
   output logic [CW-1:0] fill_count,
   output logic          busy
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_e        state;
   logic [CW-1:0] count;
   logic [CW-1:0] flush_cnt;
   logic [CW-1:0] bub;
   logic          bubbling;

   assign bubbling   = flush_cnt < bub;
   assign fill_count = count;
   assign out_data   = sr_data_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         flush_cnt <= '0;
         bub       <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  count <= ONE;
                  state <= S_FILL;
               end
            end
            S_FILL: begin
               if (flush) begin
                  state     <= S_FLUSH;
                  bub       <= DEPTH_C - count;
                  flush_cnt <= '0;
               end else if (in_valid) begin
                  count <= count + ONE;
                  if (count == DEPTH_C - ONE) state <= S_FULL;
               end
            end
            S_FULL: begin
               // accept+pop in the same shift keeps count unchanged
               if (flush) begin
                  state     <= S_FLUSH;
                  bub       <= '0;
                  flush_cnt <= '0;
               end
            end
            S_FLUSH: begin
               if (bubbling) begin
                  flush_cnt <= flush_cnt + ONE;
               end else if (out_ready) begin
                  count <= count - ONE;
                  if (count == ONE) begin
                     state     <= S_IDLE;
                     flush_cnt <= '0;
                     bub       <= '0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      sr_shift   = 1'b0;
      sr_data_in = in_data;
      busy       = 1'b0;
      if (rst) begin
         in_ready = 1'b1;
      end else begin
         unique case (state)
            S_IDLE: begin
               in_ready = 1'b1;
               sr_shift = in_valid;
            end
            S_FILL: begin
               in_ready = !flush;
               sr_shift = in_valid & !flush;
            end
            S_FULL: begin
               out_valid = 1'b1;
               in_ready  = out_ready & !flush;
               sr_shift  = in_valid & out_ready & !flush;
            end
            S_FLUSH: begin
               busy       = 1'b1;
               sr_data_in = 8'd0;
               if (bubbling) begin
                  sr_shift = 1'b1;
               end else begin
                  out_valid = 1'b1;
                  sr_shift  = out_ready;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Scoreboard bench for shiftreg_ctrl with a behavioural delay line.
module tb_shiftreg_ctrl;
   import shiftreg_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = cnt_width(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready = 1'b0;
   logic          sr_shift;
   logic [7:0]    sr_data_in;
   logic [7:0]    sr_data_out;
   logic [CW-1:0] fill_count;
   logic          busy;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   logic [7:0] line[DEPTH];

   int mcnt = 0;
   int mbub = 0;
   bit mfl  = 0;

   always #5 clk = ~clk;

   shiftreg_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .sr_shift   (sr_shift),
      .sr_data_in (sr_data_in),
      .sr_data_out(sr_data_out),
      .fill_count (fill_count),
      .busy       (busy)
   );

   // delay line the parent would instantiate next to the controller
   initial for (int i = 0; i < DEPTH; i++) line[i] = 8'hEE;
   always @(posedge clk) begin
      if (sr_shift) begin
         for (int i = DEPTH - 1; i > 0; i--) line[i] <= line[i-1];
         line[0] <= sr_data_in;
      end
   end
   assign sr_data_out = line[DEPTH-1];

   function automatic bit exp_ready();
      if (rst) return 1'b1;
      if (mfl) return 1'b0;
      if (flush && mcnt > 0) return 1'b0;
      if (mcnt < DEPTH) return 1'b1;
      return out_ready;
   endfunction

   function automatic bit exp_valid();
      if (rst) return 1'b0;
      if (mfl) return mbub == 0;
      return mcnt == DEPTH;
   endfunction

   function automatic bit exp_shift();
      if (rst) return 1'b0;
      if (mfl) return (mbub > 0) || out_ready;
      return in_valid && exp_ready();
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // occupancy model: words in the line, flush bubble countdown
   always @(posedge clk) begin
      bit acc;
      acc = in_valid && exp_ready();
      if (rst) begin
         mcnt = 0;
         mfl  = 0;
         mbub = 0;
      end else if (mfl) begin
         if (mbub > 0) begin
            mbub--;
         end else if (out_ready) begin
            mcnt--;
            if (mcnt == 0) mfl = 0;
         end
      end else if (flush && mcnt > 0) begin
         mfl  = 1;
         mbub = DEPTH - mcnt;
      end else if (acc && mcnt < DEPTH) begin
         mcnt++;
      end
   end

   // monitor
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(exp_ready()));
      chk("out_valid", int'(out_valid), int'(exp_valid()));
      chk("sr_shift", int'(sr_shift), int'(exp_shift()));
      chk("busy", int'(busy), int'(!rst && mfl));
      if (!rst) chk("fill_count", int'(fill_count), mcnt);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("out_valid_empty_sb", 1, 0);
         end else begin
            chk("out_data", int'(out_data), int'(exp_q[0]));
            if (sr_shift) void'(exp_q.pop_front());
         end
      end
   end

   task automatic drive(input bit r, input bit iv, input logic [7:0] d,
                        input bit fl, input bit ordy);
      @(posedge clk);
      #1;
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      flush     = fl;
      out_ready = ordy;
      if (r) exp_q.delete();
      else if (iv && exp_ready()) exp_q.push_back(d);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, ordy);
   endtask

   initial begin
      drive(1, 0, 8'h00, 0, 0);
      drive(1, 1, 8'hA5, 0, 0);
      idle(1, 0);
      // fill to FULL
      drive(0, 1, 8'h11, 0, 0);
      drive(0, 1, 8'h22, 0, 0);
      drive(0, 1, 8'h33, 0, 0);
      drive(0, 1, 8'h44, 0, 0);
      idle(2, 1);
      // backpressure then shift through
      drive(0, 1, 8'h55, 0, 0);
      drive(0, 1, 8'h55, 0, 1);
      idle(1, 0);
      // flush with two words loaded
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'hA1, 0, 0);
      drive(0, 1, 8'hA2, 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      idle(6, 1);
      // drain stalled by out_ready low
      drive(0, 1, 8'hB1, 0, 0);
      drive(0, 1, 8'hB2, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      idle(5, 0);
      drive(0, 0, 8'h00, 1, 1);
      idle(4, 1);
      // flush beats in_valid; flush in IDLE ignored
      drive(0, 1, 8'hC1, 0, 0);
      drive(0, 1, 8'hC2, 1, 0);
      idle(5, 1);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 1, 8'hC3, 1, 0);
      idle(1, 0);
      drive(1, 0, 8'h00, 0, 0);
      // reset mid-flush, then fresh fill
      drive(0, 1, 8'hD1, 0, 0);
      drive(0, 1, 8'hD2, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 0, 0);
      drive(1, 1, 8'hDD, 0, 1);
      drive(0, 1, 8'hE1, 0, 0);
      drive(0, 1, 8'hE2, 0, 0);
      drive(0, 1, 8'hE3, 0, 0);
      drive(0, 1, 8'hE4, 0, 0);
      idle(2, 0);
      drive(0, 1, 8'hE5, 0, 1);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 299) == 0,
               $urandom_range(0, 9) < 7,
               8'($urandom),
               $urandom_range(0, 14) == 0,
               $urandom_range(0, 9) < 6);
      end
      idle(12, 1);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
